// File: rtl/scr_csr_pkg.sv
// scr_csr_pkg: shared CSR addresses, op encoding, bit positions and WARL masks.
package scr_csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_MSIP_BIT     = 3;
    localparam int unsigned MIP_MTIP_BIT     = 7;
    localparam int unsigned MIP_MEIP_BIT     = 11;

    localparam logic [31:0] MSTATUS_MPP_VAL = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;

endpackage

// File: rtl/scr_csr_counter64.sv
// scr_csr_counter64: 64-bit counter with per-half write enables; any write beats the increment.
import scr_csr_pkg::*;

module scr_csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] count_o
);

    // Count register: reset, then writes to either half, else increment with full carry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (we_lo_i || we_hi_i) begin
            if (we_lo_i) count_o[31:0]  <= wdata_i[31:0];
            if (we_hi_i) count_o[63:32] <= wdata_i[63:32];
        end else if (inc_i) begin
            count_o <= count_o + 64'd1;
        end
    end

endmodule

// File: rtl/scr_csr_file.sv
// scr_csr_file: machine-mode CSR file with trap/mret sequencing and interrupt gating.
// Optional counters (mcycle/minstret) are built only when SCR_CSR_COUNTERS_EN is defined.
import scr_csr_pkg::*;

module scr_csr_file #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] VENDOR_ID = '0,
    parameter logic [XLEN-1:0] ARCH_ID   = '0,
    parameter logic [XLEN-1:0] IMP_ID    = '0,
    parameter logic [XLEN-1:0] MISA_VAL  = XLEN'(32'h4000_0100),
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            csr_valid_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            instret_i,
    input  logic            irq_sw_i,
    input  logic            irq_tim_i,
    input  logic            irq_ext_i,
    output logic            irq_take_o,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o
);

    csr_op_t         op;
    logic            mie_bit, mpie_bit;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] mstatus_val, mip_val, old_val, new_val, vec_base;
    logic [63:0]     cycle_cnt, instret_cnt;
    logic            implemented, wr_op, do_wr;

    assign op = csr_op_t'(csr_op_i);

    // Architectural views of mstatus and mip.
    always_comb begin
        mstatus_val                   = XLEN'(MSTATUS_MPP_VAL);
        mstatus_val[MSTATUS_MIE_BIT]  = mie_bit;
        mstatus_val[MSTATUS_MPIE_BIT] = mpie_bit;
        mip_val                       = '0;
        mip_val[MIP_MSIP_BIT]         = irq_sw_i;
        mip_val[MIP_MTIP_BIT]         = irq_tim_i;
        mip_val[MIP_MEIP_BIT]         = irq_ext_i;
    end

    // Address decode: pre-write value and whether the address exists.
    always_comb begin
        implemented = 1'b1;
        old_val     = '0;
        case (csr_addr_i)
            ADDR_MVENDORID: old_val = VENDOR_ID;
            ADDR_MARCHID:   old_val = ARCH_ID;
            ADDR_MIMPID:    old_val = IMP_ID;
            ADDR_MHARTID:   old_val = HART_ID;
            ADDR_MSTATUS:   old_val = mstatus_val;
            ADDR_MISA:      old_val = MISA_VAL;
            ADDR_MIE:       old_val = mie_q;
            ADDR_MTVEC:     old_val = mtvec_q;
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = mepc_q;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MTVAL:     old_val = mtval_q;
            ADDR_MIP:       old_val = mip_val;
            ADDR_MCYCLE:    old_val = XLEN'(cycle_cnt);
            ADDR_MINSTRET:  old_val = XLEN'(instret_cnt);
            ADDR_MCYCLEH: begin
                implemented = (XLEN == 32);
                old_val     = XLEN'(cycle_cnt[63:32]);
            end
            ADDR_MINSTRETH: begin
                implemented = (XLEN == 32);
                old_val     = XLEN'(instret_cnt[63:32]);
            end
            default:        implemented = 1'b0;
        endcase
    end

    // Read-modify-write value and legality.
    always_comb begin
        case (op)
            CSR_OP_RW: new_val = csr_wdata_i;
            CSR_OP_RS: new_val = old_val | csr_wdata_i;
            CSR_OP_RC: new_val = old_val & ~csr_wdata_i;
            default:   new_val = old_val;
        endcase
    end

    assign wr_op         = (op == CSR_OP_RW) ||
                           (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (|csr_wdata_i));
    assign csr_illegal_o = csr_valid_i && (!implemented || ((csr_addr_i[11:10] == 2'b11) && wr_op));
    assign csr_rdata_o   = csr_illegal_o ? '0 : old_val;
    assign do_wr         = csr_valid_i && wr_op && !csr_illegal_o && !trap_i && !mret_i;

    assign irq_take_o = mie_bit && (|(mip_val & mie_q));
    assign mepc_o     = mepc_q;
    assign vec_base   = {mtvec_q[XLEN-1:2], 2'b00};

    // Trap target: direct, or vectored for interrupts when MODE=1.
    always_comb begin
        trap_vec_o = vec_base;
        if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[XLEN-1]) begin
            trap_vec_o = vec_base + XLEN'({trap_cause_i[XLEN-2:0], 2'b00});
        end
    end

    // Machine state: reset > trap > mret > CSR write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_bit    <= 1'b0;
            mpie_bit   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_i) begin
            mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_val_i;
            mpie_bit <= mie_bit;
            mie_bit  <= 1'b0;
        end else if (mret_i) begin
            mie_bit  <= mpie_bit;
            mpie_bit <= 1'b1;
        end else if (do_wr) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    mie_bit  <= new_val[MSTATUS_MIE_BIT];
                    mpie_bit <= new_val[MSTATUS_MPIE_BIT];
                end
                ADDR_MIE:      mie_q      <= new_val & XLEN'(MIE_WMASK);
                ADDR_MTVEC:    mtvec_q    <= {new_val[XLEN-1:2], new_val[1] ? 2'b00 : new_val[1:0]};
                ADDR_MSCRATCH: mscratch_q <= new_val;
                ADDR_MEPC:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_q   <= new_val;
                ADDR_MTVAL:    mtval_q    <= new_val;
                default: ;
            endcase
        end
    end

`ifdef SCR_CSR_COUNTERS_EN
    logic [63:0] cnt_wdata;
    logic        cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;

    // On XLEN=32 each half is written separately; on XLEN=64 the low address covers both.
    assign cnt_wdata = (XLEN == 32) ? {2{32'(new_val)}} : 64'(new_val);
    assign cyc_we_lo = do_wr && (csr_addr_i == ADDR_MCYCLE);
    assign cyc_we_hi = do_wr && (((XLEN == 32) && (csr_addr_i == ADDR_MCYCLEH)) ||
                                 ((XLEN == 64) && (csr_addr_i == ADDR_MCYCLE)));
    assign ins_we_lo = do_wr && (csr_addr_i == ADDR_MINSTRET);
    assign ins_we_hi = do_wr && (((XLEN == 32) && (csr_addr_i == ADDR_MINSTRETH)) ||
                                 ((XLEN == 64) && (csr_addr_i == ADDR_MINSTRET)));

    scr_csr_counter64 u_cycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .we_lo_i (cyc_we_lo),
        .we_hi_i (cyc_we_hi),
        .wdata_i (cnt_wdata),
        .count_o (cycle_cnt)
    );

    scr_csr_counter64 u_instret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .we_lo_i (ins_we_lo),
        .we_hi_i (ins_we_hi),
        .wdata_i (cnt_wdata),
        .count_o (instret_cnt)
    );
`else
    logic unused_instret;

    assign cycle_cnt      = '0;
    assign instret_cnt    = '0;
    assign unused_instret = instret_i;
`endif

endmodule

// File: tb/tb_scr_csr_file.sv
// tb_scr_csr_file: directed checks plus randomized traffic against a behavioural CSR model.
module tb_scr_csr_file;

`ifdef SCR_CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, csr_valid, trap, mret, instret, irq_sw, irq_tim, irq_ext;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, trap_cause, trap_pc, trap_val;
    logic [31:0] csr_rdata, trap_vec, mepc;
    logic        csr_illegal, irq_take;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Behavioural model state
    bit          m_mie_b, m_mpie_b;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    always #5 clk = ~clk;

    scr_csr_file #(.XLEN(32), .HART_ID(32'd3)) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_valid_i(csr_valid), .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
        .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
        .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .trap_val_i(trap_val),
        .mret_i(mret), .instret_i(instret),
        .irq_sw_i(irq_sw), .irq_tim_i(irq_tim), .irq_ext_i(irq_ext),
        .irq_take_o(irq_take), .trap_vec_o(trap_vec), .mepc_o(mepc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bit model_writes(input logic [1:0] op, input logic [31:0] wd);
        return (op == 2'b01) || ((op >= 2'b10) && (wd != 0));
    endfunction

    function automatic logic [31:0] model_mip();
        return (irq_ext ? 32'd2048 : 32'd0) + (irq_tim ? 32'd128 : 32'd0) + (irq_sw ? 32'd8 : 32'd0);
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [31:0] v, output bit impl);
        impl = 1'b1;
        v    = 32'd0;
        case (a)
            12'hF11, 12'hF12, 12'hF13: v = 32'd0;
            12'hF14: v = 32'd3;
            12'h300: v = 32'h1800 + (m_mpie_b ? 32'h80 : 32'h0) + (m_mie_b ? 32'h8 : 32'h0);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = model_mip();
            12'hB00: v = CNT_EN ? m_cycle[31:0]   : 32'd0;
            12'hB80: v = CNT_EN ? m_cycle[63:32]  : 32'd0;
            12'hB02: v = CNT_EN ? m_instret[31:0] : 32'd0;
            12'hB82: v = CNT_EN ? m_instret[63:32] : 32'd0;
            default: impl = 1'b0;
        endcase
    endfunction

    function automatic bit model_illegal();
        logic [31:0] v;
        bit impl;
        model_read(csr_addr, v, impl);
        return csr_valid && (!impl || ((csr_addr >= 12'hC00) && model_writes(csr_op, csr_wdata)));
    endfunction

    // Advance the model by one clock edge using the inputs presented in that cycle.
    task automatic model_step();
        logic [31:0] old, nv;
        bit          impl;
        logic [63:0] cyc_n, ins_n;
        if (rst) begin
            m_mie_b = 0; m_mpie_b = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
            return;
        end
        model_read(csr_addr, old, impl);
        case (csr_op)
            2'b01:   nv = csr_wdata;
            2'b10:   nv = old | csr_wdata;
            2'b11:   nv = old & ~csr_wdata;
            default: nv = old;
        endcase
        cyc_n = m_cycle + 64'd1;
        ins_n = m_instret + (instret ? 64'd1 : 64'd0);
        if (trap) begin
            m_mepc = trap_pc - (trap_pc % 4); m_mcause = trap_cause; m_mtval = trap_val;
            m_mpie_b = m_mie_b; m_mie_b = 0;
        end else if (mret) begin
            m_mie_b = m_mpie_b; m_mpie_b = 1;
        end else if (csr_valid && model_writes(csr_op, csr_wdata) && !model_illegal()) begin
            case (csr_addr)
                12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
                12'h304: m_mie = nv & 32'h888;
                12'h305: m_mtvec = (nv % 4 >= 2) ? nv - (nv % 4) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv - (nv % 4);
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: cyc_n = {m_cycle[63:32], nv};
                12'hB80: cyc_n = {nv, m_cycle[31:0]};
                12'hB02: ins_n = {m_instret[63:32], nv};
                12'hB82: ins_n = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        if (CNT_EN) begin
            m_cycle   = cyc_n;
            m_instret = ins_n;
        end
    endtask

    // Compare all outputs against the model, mid-cycle.
    task automatic compare();
        logic [31:0] v, vec;
        bit impl, ill;
        model_read(csr_addr, v, impl);
        ill = model_illegal();
        check("illegal", 64'(csr_illegal), 64'(ill));
        if (csr_valid) check("rdata", 64'(csr_rdata), ill ? 64'd0 : 64'(v));
        check("irq_take", 64'(irq_take), 64'(m_mie_b && ((model_mip() & m_mie) != 0)));
        vec = m_mtvec - (m_mtvec % 4);
        if ((m_mtvec % 4 == 1) && trap_cause[31]) vec = vec + 4 * (trap_cause & 32'h7FFF_FFFF);
        check("trap_vec", 64'(trap_vec), 64'(vec));
        check("mepc", 64'(mepc), 64'(m_mepc));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (checking) compare();
    end

    task automatic next();
        @(posedge clk);
        #1;
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        trap = 0; mret = 0; instret = 0; rst = 0;
    endtask

    task automatic access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = wd;
        @(negedge clk);
    endtask

    logic [11:0] addrs [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hB00,
                                12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'hF15, 12'h3A0, 12'h000};

    initial begin
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        trap = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret = 0; instret = 0;
        irq_sw = 0; irq_tim = 0; irq_ext = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        checking = 1;

        // Reset values and read-only identity registers
        access(2'b00, 12'h301, 0); check("misa", 64'(csr_rdata), 64'h4000_0100);
        check("mepc_rst", 64'(mepc), 64'h0); check("vec_rst", 64'(trap_vec), 64'h0); next();
        access(2'b00, 12'hF14, 0); check("mhartid", 64'(csr_rdata), 64'h3); next();
        access(2'b00, 12'h300, 0); check("mstatus_rst", 64'(csr_rdata), 64'h1800); next();

        // mie WARL and set/clear
        access(2'b01, 12'h304, 32'hFFFF_FFFF); next();
        access(2'b00, 12'h304, 0); check("mie_warl", 64'(csr_rdata), 64'h888); next();
        access(2'b11, 12'h304, 32'h8); next();
        access(2'b00, 12'h304, 0); check("mie_rc", 64'(csr_rdata), 64'h880); next();
        access(2'b10, 12'hF11, 0); check("ro_rs0_legal", 64'(csr_illegal), 64'h0); next();

        // Illegal accesses
        access(2'b01, 12'hF11, 32'h5);
        check("ro_rw_illegal", 64'(csr_illegal), 64'h1); check("ro_rw_rdata", 64'(csr_rdata), 64'h0); next();
        access(2'b00, 12'h7C0, 0); check("unimpl_illegal", 64'(csr_illegal), 64'h1); next();

        // Interrupt gating, trap entry, vectored target, mret
        access(2'b01, 12'h300, 32'h8); next();
        access(2'b01, 12'h304, 32'h80); next();
        irq_tim = 1;
        @(negedge clk); check("irq_take", 64'(irq_take), 64'h1); next();
        access(2'b01, 12'h305, 32'h101); next();
        trap = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1002; trap_val = 32'hDEAD;
        @(negedge clk); check("trap_vec_vectored", 64'(trap_vec), 64'h11C); next();
        irq_tim = 0;
        check("mepc_trap", 64'(mepc), 64'h1000);
        access(2'b00, 12'h300, 0); check("mstatus_trap", 64'(csr_rdata), 64'h1880); next();
        mret = 1; next();
        access(2'b00, 12'h300, 0); check("mstatus_mret", 64'(csr_rdata), 64'h1888); next();

        // CSR write dropped when a trap is taken in the same cycle
        access(2'b01, 12'h340, 32'h55); next();
        trap = 1; access(2'b01, 12'h340, 32'hAA); next();
        access(2'b00, 12'h340, 0); check("mscratch_trap_drop", 64'(csr_rdata), 64'h55); next();

        // Counter carry from low to high half
        if (CNT_EN) begin
            access(2'b01, 12'hB00, 32'hFFFF_FFFF); next();
            access(2'b01, 12'hB80, 32'h0); next();
            access(2'b00, 12'hB80, 0); check("mcycleh_pre", 64'(csr_rdata), 64'h0); next();
            access(2'b00, 12'hB80, 0); check("mcycleh_carry", 64'(csr_rdata), 64'h1); next();
        end

        // Counter after reset plus ten cycles
        rst = 1; next();
        repeat (10) next();
        access(2'b00, 12'hB00, 0);
        check("mcycle_illegal", 64'(csr_illegal), 64'h0);
        if (CNT_EN) check("mcycle_ge10", 64'(csr_rdata >= 32'd10), 64'h1);
        else        check("mcycle_off", 64'(csr_rdata), 64'h0);
        next();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            csr_valid  = ($urandom_range(0, 3) != 0);
            csr_op     = 2'($urandom_range(0, 3));
            csr_addr   = addrs[$urandom_range(0, 20)];
            case ($urandom_range(0, 3))
                0:       csr_wdata = 32'd0;
                1:       csr_wdata = 32'($urandom_range(0, 15));
                default: csr_wdata = $urandom;
            endcase
            trap       = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom;
            trap_pc    = $urandom;
            trap_val   = $urandom;
            mret       = ($urandom_range(0, 15) == 0);
            instret    = 1'($urandom_range(0, 1));
            irq_sw     = 1'($urandom_range(0, 1));
            irq_tim    = 1'($urandom_range(0, 1));
            irq_ext    = 1'($urandom_range(0, 1));
            next();
        end

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
